uart_frame_loader: RTL
======================

Name: uart_frame_loader

Overview:
- Parametrised successor to the single-target ICCM programming controller.
- Parses a framed, checksummed byte stream from the UART receiver. Assembles DATA_W-bit words and writes them to one of NUM_TGT memories (instruction RAM, data RAM, ...) through a req/gnt port.
- Holds the core in reset until a valid END frame arrives.
- Adds over the previous loader: multi-target writes, per-frame start address, stall handshake, checksum, timeout, error reporting, and re-programming after release.

Parameters:
- DATA_W, 32, memory word width. Multiple of 8, range 8..64. BPW = DATA_W/8.
- ADDR_W, 14, word-address width. ADDR_BYTES = ceil(ADDR_W/8), derived.
- NUM_TGT, 2, number of target memories, range 1..127.
- LEN_W, 16, frame word-count width (2 length bytes, little-endian).
- TIMEOUT_CYC, 0, inter-byte timeout in cycles. 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rx_dv_i  in  1  one-cycle strobe; received byte valid
- rx_byte_i  in  8  received byte
- mem_req_o  out  1  write request
- mem_sel_o  out  NUM_TGT  one-hot target select
- mem_addr_o  out  ADDR_W  word address
- mem_wdata_o  out  DATA_W  write data
- mem_be_o  out  BPW  byte enables; all ones when mem_req_o=1
- mem_gnt_i  in  1  write accepted in the current cycle
- core_rst_no  out  1  core reset, 0 = held in reset
- busy_o  out  1  frame in progress (state not IDLE/DONE)
- err_o  out  4  sticky errors: [0] checksum, [1] bad cmd, [2] overflow, [3] timeout
- words_o  out  32  count of granted writes, wraps

Behaviour:
- Reset values:
  - mem_req_o=0, mem_sel_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0.
  - core_rst_no=0, busy_o=0, err_o=0, words_o=0.
  - State IDLE.
- Frame formats:
  - WRITE: A5, CMD(0..NUM_TGT-1), ADDR (ADDR_BYTES, LSB first), LEN (2 bytes, LSB first), LEN*BPW payload bytes, CSUM.
  - END: A5, FF, CSUM.
  - CSUM = 8-bit sum mod 256 of every byte after A5, excluding CSUM itself.
- State transitions (advance only on rx_dv_i=1):
  - IDLE -> CMD on A5; all other bytes ignored.
  - CMD: FF -> CSUM (END). Value < NUM_TGT -> ADDR. Anything else: set err_o[1], -> IDLE.
  - ADDR -> LEN after ADDR_BYTES bytes. Address bits above ADDR_W are discarded.
  - LEN -> DATA, or -> CSUM if LEN=0.
  - DATA -> CSUM after LEN*BPW bytes.
  - CSUM: on mismatch set err_o[0], -> IDLE. On match:
    - WRITE -> IDLE.
    - END -> DONE if err_o==0, else -> IDLE.
  - DONE: core_rst_no=1 from the cycle after the END CSUM byte. An A5 byte drops core_rst_no to 0 in the next cycle and enters CMD (re-program).
- Word assembly:
  - Payload is little-endian; the first byte lands in [7:0].
  - When BPW bytes have been collected, the word loads the single holding register and mem_req_o asserts the next cycle.
  - Address starts at ADDR and increments by 1 per word, wrapping modulo 2^ADDR_W.
- Write handshake:
  - addr, wdata, sel and be stay stable while mem_req_o=1.
  - The transfer completes in a cycle where mem_req_o & mem_gnt_i. words_o increments then.
  - mem_req_o drops the following cycle unless a new word is loaded.
  - If a new word completes while the previous one is still pending and not granted that same cycle: set err_o[2] and drop the new word. The pending write continues.
- Pending writes and CSUM: a pending write is not cancelled by a CSUM error, a timeout, or entering IDLE. The error is only flagged; memory contents are not rolled back.
- Timeout (TIMEOUT_CYC>0):
  - The counter clears on every rx_dv_i and counts only in CMD/ADDR/LEN/DATA/CSUM.
  - On reaching TIMEOUT_CYC: set err_o[3], -> IDLE, discard the partial word.
- Errors: err_o bits are sticky until rst_ni. While any bit is set, END never releases core reset.
- rst_ni low mid-frame: asynchronous return to reset values. Any in-flight request is abandoned.

Test Plan:
- Reset check: assert rst_ni low mid-payload -> all outputs at reset values immediately; a subsequent full frame is accepted.
- Write and release (DATA_W=32, ADDR_W=14, gnt=1), bytes A5 00 10 00 02 00 11 22 33 44 55 66 77 88 76:
  - writes sel=01, addr 0x0010, data 0x44332211; then addr 0x0011, data 0x88776655; words_o=2.
  - then A5 FF FF -> core_rst_no=1 the following cycle.
- Same WRITE frame with CSUM 77 -> err_o=0001, both writes still occur; A5 FF FF then leaves core_rst_no=0. CMD 05 with NUM_TGT=2 -> err_o[1] set.
- Overflow: gnt low for 10 cycles, payload strobed every cycle, LEN=2 -> err_o[2] set, exactly one write granted once gnt rises, words_o=1.
- Wrap: ADDR=0x3FFF, LEN=2 -> writes at 0x3FFF then 0x0000.
- Timeout and re-program:
  - TIMEOUT_CYC=100, stop after the ADDR bytes -> err_o[3] set 100 cycles after the last byte, busy_o=0.
  - Separately, after release in DONE, send A5 -> core_rst_no=0 next cycle; a new valid frame plus END -> core_rst_no=1.

Source files
------------

// File: rtl/uart_frame_loader.sv
// UART frame loader: parses checksummed A5-framed byte stream into word writes
// across NUM_TGT memories and holds the core in reset until a clean END frame.
//
// state  | meaning
// S_IDLE | waiting for A5 sync byte, core held in reset
// S_CMD  | next byte selects target (0..NUM_TGT-1) or END (FF)
// S_ADDR | collecting ADDR_BYTES start-address bytes, LSB first
// S_LEN  | collecting 2 word-count bytes, LSB first
// S_DATA | collecting LEN*BPW payload bytes, issuing word writes
// S_CSUM | comparing checksum byte against running sum
// S_DONE | core released; A5 starts a re-program
module uart_frame_loader #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 14,
    parameter int NUM_TGT     = 2,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_dv_i,
    input  logic [7:0]            rx_byte_i,
    output logic                  mem_req_o,
    output logic [NUM_TGT-1:0]    mem_sel_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    input  logic                  mem_gnt_i,
    output logic                  core_rst_no,
    output logic                  busy_o,
    output logic [3:0]            err_o,
    output logic [31:0]           words_o
);

    localparam int BPW        = DATA_W / 8;
    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int AB_W       = ADDR_BYTES * 8;
    localparam int CNT_W      = LEN_W + 4;
    localparam int TMO_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [3:0] BLEFT_INIT = 4'(BPW - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_is_end;
    logic [NUM_TGT-1:0]  r_tgt_oh;
    logic [AB_W-1:0]     r_addr_acc;
    logic [LEN_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_bleft;
    logic [DATA_W-1:0]   r_word;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [7:0]          r_csum;
    logic                r_req;
    logic [NUM_TGT-1:0]  r_sel;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_err;
    logic [31:0]         r_words;
    logic [TMO_W-1:0]    r_tmo;

    logic [NUM_TGT-1:0]  w_cmd_oh;
    logic                w_cmd_ok;
    logic [AB_W-1:0]     w_addr_full;
    logic [LEN_W-1:0]    w_len_full;
    logic [DATA_W-1:0]   w_word_full;
    logic [CNT_W-1:0]    w_data_bytes;
    logic                w_busy;
    logic                w_tmo_fire;
    logic                w_can_load;
    logic                w_word_done;
    logic                w_bad_cmd;
    logic                w_csum_bad;

    always_comb begin
        w_cmd_oh = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            w_cmd_oh[i] = (rx_byte_i == 8'(i));
        end
    end

    // Multi-byte fields shift in from the top so the first byte ends up in [7:0].
    assign w_cmd_ok     = |w_cmd_oh;
    assign w_addr_full  = (r_addr_acc >> 8) | (AB_W'(rx_byte_i) << (AB_W - 8));
    assign w_len_full   = (r_len >> 8) | (LEN_W'(rx_byte_i) << (LEN_W - 8));
    assign w_word_full  = (r_word >> 8) | (DATA_W'(rx_byte_i) << (DATA_W - 8));
    assign w_data_bytes = CNT_W'(w_len_full) * CNT_W'(BPW);
    assign w_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_tmo_fire   = (TIMEOUT_CYC > 0) && w_busy && !rx_dv_i && (r_tmo == TMO_W'(1));
    assign w_can_load   = !r_req || mem_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_done = 1'b0;
        w_bad_cmd   = 1'b0;
        w_csum_bad  = 1'b0;
        if (w_tmo_fire) begin
            w_state_nxt = S_IDLE;
        end else if (rx_dv_i) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_byte_i == 8'hA5) w_state_nxt = S_CMD;
                end
                S_CMD: begin
                    if (rx_byte_i == 8'hFF) begin
                        w_state_nxt = S_CSUM;
                    end else if (w_cmd_ok) begin
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_bad_cmd   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ADDR: begin
                    if (r_cnt == '0) w_state_nxt = S_LEN;
                end
                S_LEN: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = (w_len_full == '0) ? S_CSUM : S_DATA;
                    end
                end
                S_DATA: begin
                    w_word_done = (r_bleft == 4'd0);
                    if (r_cnt == CNT_W'(1)) w_state_nxt = S_CSUM;
                end
                S_CSUM: begin
                    if (rx_byte_i != r_csum) begin
                        w_csum_bad  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_is_end && (r_err == 4'b0)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DONE: begin
                    if (rx_byte_i == 8'hA5) w_state_nxt = S_CMD;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_is_end   <= 1'b0;
            r_tgt_oh   <= '0;
            r_addr_acc <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_bleft    <= '0;
            r_word     <= '0;
            r_wr_addr  <= '0;
            r_csum     <= '0;
            r_req      <= 1'b0;
            r_sel      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= '0;
            r_words    <= '0;
            r_tmo      <= TMO_W'(TIMEOUT_CYC);
        end else begin
            // Inter-byte timer: reloads on every byte, runs down only mid-frame.
            if (rx_dv_i || !w_busy) begin
                r_tmo <= TMO_W'(TIMEOUT_CYC);
            end else if (r_tmo != '0) begin
                r_tmo <= r_tmo - TMO_W'(1);
            end

            if (rx_dv_i) begin
                case (r_state)
                    S_CMD: begin
                        r_csum   <= rx_byte_i;
                        r_is_end <= (rx_byte_i == 8'hFF);
                        r_tgt_oh <= w_cmd_oh;
                        r_cnt    <= CNT_W'(ADDR_BYTES - 1);
                    end
                    S_ADDR: begin
                        r_csum     <= r_csum + rx_byte_i;
                        r_addr_acc <= w_addr_full;
                        if (r_cnt == '0) begin
                            r_wr_addr <= ADDR_W'(w_addr_full);
                            r_cnt     <= CNT_W'(1);
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_LEN: begin
                        r_csum <= r_csum + rx_byte_i;
                        r_len  <= w_len_full;
                        if (r_cnt == '0) begin
                            r_cnt   <= w_data_bytes;
                            r_bleft <= BLEFT_INIT;
                            r_word  <= '0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        r_csum <= r_csum + rx_byte_i;
                        r_cnt  <= r_cnt - CNT_W'(1);
                        r_word <= w_word_full;
                        if (r_bleft == 4'd0) begin
                            r_bleft   <= BLEFT_INIT;
                            r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        end else begin
                            r_bleft <= r_bleft - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end

            if (r_req && mem_gnt_i) begin
                r_words <= r_words + 32'd1;
                r_req   <= 1'b0;
            end

            // A word arriving while the previous one is still ungranted is dropped.
            if (w_word_done) begin
                if (w_can_load) begin
                    r_req   <= 1'b1;
                    r_addr  <= r_wr_addr;
                    r_wdata <= w_word_full;
                    r_sel   <= r_tgt_oh;
                end else begin
                    r_err[2] <= 1'b1;
                end
            end

            if (w_csum_bad) r_err[0] <= 1'b1;
            if (w_bad_cmd)  r_err[1] <= 1'b1;
            if (w_tmo_fire) r_err[3] <= 1'b1;
        end
    end

    assign mem_req_o   = r_req;
    assign mem_sel_o   = r_sel;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = {BPW{r_req}};
    assign core_rst_no = (r_state == S_DONE);
    assign busy_o      = w_busy;
    assign err_o       = r_err;
    assign words_o     = r_words;

endmodule
